// File: rtl/rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module   : rd_fwft_stage
// Brief    : Async-FIFO read front end: drains rinc/rempty/rdata into a
//            two-entry buffer and presents a registered FWFT valid/ready stream.
// Option   : RD_FWFT_PARITY_EN (rdata gains an even-parity MSB, sticky perr)
// Revision : 1.0 - initial release
// ============================================================================
module rd_fwft_stage #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
`ifdef RD_FWFT_PARITY_EN
  input  logic [DSIZE:0]   rdata,
`else
  input  logic [DSIZE-1:0] rdata,
`endif
  output logic             rinc,
  input  logic             rflush,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       m_level,
  output logic             perr
);

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] buf0_q, buf0_d;
  logic [DSIZE-1:0] buf1_q, buf1_d;
  logic             push;
  logic             pop;
  logic [DSIZE-1:0] wdata;

  // Only registered state and FIFO flags feed rinc; m_ready never does.
  assign rinc    = !rempty && (occ_q != OCC_TWO) && !rflush;
  assign push    = rinc;
  assign pop     = (occ_q != OCC_EMPTY) && m_ready && !rflush;
  assign wdata   = rdata[DSIZE-1:0];

  assign m_valid = (occ_q != OCC_EMPTY);
  assign m_data  = buf0_q;
  assign m_level = occ_q;

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    if (pop && (occ_q == OCC_TWO)) begin
      buf0_d = buf1_q;
    end
    // Push lands at index occ - pop.
    if (push) begin
      if ((occ_q == OCC_EMPTY) || ((occ_q == OCC_ONE) && pop)) begin
        buf0_d = wdata;
      end else begin
        buf1_d = wdata;
      end
    end
    if (rflush) begin
      occ_d = OCC_EMPTY;
    end else begin
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q  <= OCC_EMPTY;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

`ifdef RD_FWFT_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (push && (^rdata)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_fwft_stage
// Brief    : Directed and randomized checks of rd_fwft_stage against a small
//            FIFO model and a scoreboard of rinc-consumed words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_fwft_stage;

  localparam int DSIZE = 8;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic             rempty;
  logic             rinc;
  logic             rflush;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
  logic [1:0]       m_level;
  logic             perr;
`ifdef RD_FWFT_PARITY_EN
  logic [DSIZE:0]   rdata;
`else
  logic [DSIZE-1:0] rdata;
`endif

  int         tests = 0;
  int         fails = 0;
  logic [7:0] src[$];
  bit         hold_empty = 1'b0;
  bit         bad_par    = 1'b0;

  always #5 rclk = ~rclk;

  rd_fwft_stage #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .rflush  (rflush),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .m_level (m_level),
    .perr    (perr)
  );

  // FIFO read-port model: head word on rdata, empty when queue empty or held.
  task automatic drive_fifo();
    logic [7:0] w;
    w = (src.size() != 0) ? src[0] : 8'h00;
    rempty = hold_empty || (src.size() == 0);
`ifdef RD_FWFT_PARITY_EN
    rdata = {(^w) ^ bad_par, w};
`else
    rdata = w;
`endif
    #1;
  endtask

  task automatic step();
    bit was_rinc;
    was_rinc = rinc;
    @(posedge rclk);
    #1;
    if (was_rinc && (src.size() != 0)) src.delete(0);
    drive_fifo();
  endtask

  task automatic quiesce();
    src.delete();
    hold_empty = 1'b0;
    m_ready    = 1'b0;
    rflush     = 1'b1;
    drive_fifo();
    step();
    rflush = 1'b0;
    drive_fifo();
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; rflush = 1'b0; m_ready = 1'b0;
    src.delete();
    drive_fifo();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        rrst_n = 1'b1;
        #1;
      end
      tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, m_valid); end
      tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL reset_rinc cyc%0d got %b exp 0", i, rinc); end
      tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_data cyc%0d got %h exp 00", i, m_data); end
      tests++; if (m_level !== 2'd0) begin fails++; $display("FAIL reset_level cyc%0d got %0d exp 0", i, m_level); end
      tests++; if (perr !== 1'b0) begin fails++; $display("FAIL reset_perr cyc%0d got %b exp 0", i, perr); end
      step();
    end
  endtask

  task automatic test_stream();
    logic       exp_rinc[5];
    logic       exp_v[5];
    logic [7:0] exp_d[5];
    exp_rinc = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_v    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d    = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    src = '{8'h11, 8'h22, 8'h33};
    m_ready = 1'b1;
    drive_fifo();
    for (int i = 0; i < 5; i++) begin
      tests++; if (rinc !== exp_rinc[i]) begin fails++; $display("FAIL stream_rinc cyc%0d got %b exp %b", i, rinc, exp_rinc[i]); end
      tests++; if (m_valid !== exp_v[i]) begin fails++; $display("FAIL stream_valid cyc%0d got %b exp %b", i, m_valid, exp_v[i]); end
      if (exp_v[i]) begin
        tests++; if (m_data !== exp_d[i]) begin fails++; $display("FAIL stream_data cyc%0d got %h exp %h", i, m_data, exp_d[i]); end
      end
      step();
    end
    quiesce();
  endtask

  task automatic test_stall();
    logic       exp_rinc[4];
    logic [1:0] exp_lvl[4];
    logic [7:0] got[$];
    exp_rinc = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_lvl  = '{2'd0, 2'd1, 2'd2, 2'd2};
    src = '{8'h41, 8'h42, 8'h43, 8'h44};
    m_ready = 1'b0;
    drive_fifo();
    for (int i = 0; i < 4; i++) begin
      tests++; if (rinc !== exp_rinc[i]) begin fails++; $display("FAIL stall_rinc cyc%0d got %b exp %b", i, rinc, exp_rinc[i]); end
      tests++; if (m_level !== exp_lvl[i]) begin fails++; $display("FAIL stall_level cyc%0d got %0d exp %0d", i, m_level, exp_lvl[i]); end
      if (i > 0) begin
        tests++; if (m_data !== 8'h41) begin fails++; $display("FAIL stall_hold cyc%0d got %h exp 41", i, m_data); end
      end
      step();
    end
    m_ready = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid && m_ready) got.push_back(m_data);
      step();
    end
    tests++; if (got.size() !== 4) begin fails++; $display("FAIL stall_count got %0d exp 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      tests++; if (got[i] !== 8'(8'h41 + i)) begin fails++; $display("FAIL stall_order idx%0d got %h exp %h", i, got[i], 8'(8'h41 + i)); end
    end
    tests++; if (m_level !== 2'd0) begin fails++; $display("FAIL stall_final_level got %0d exp 0", m_level); end
    quiesce();
  endtask

  task automatic test_flush();
    src = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    m_ready = 1'b0;
    drive_fifo();
    step();
    step();
    tests++; if (m_level !== 2'd2) begin fails++; $display("FAIL flush_pre_level got %0d exp 2", m_level); end
    m_ready = 1'b1;
    rflush  = 1'b1;
    #1;
    tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL flush_rinc got %b exp 0", rinc); end
    step();
    rflush  = 1'b0;
    m_ready = 1'b0;
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", m_valid); end
    tests++; if (rinc !== 1'b1) begin fails++; $display("FAIL flush_after_rinc got %b exp 1", rinc); end
    step();
    tests++; if (m_valid !== 1'b1) begin fails++; $display("FAIL flush_next_valid got %b exp 1", m_valid); end
    tests++; if (m_data !== 8'hA3) begin fails++; $display("FAIL flush_next_data got %h exp a3", m_data); end
    quiesce();
  endtask

  task automatic test_pulse();
    src = '{8'h5A, 8'h5B};
    hold_empty = 1'b0;
    m_ready = 1'b0;
    drive_fifo();
    tests++; if (rinc !== 1'b1) begin fails++; $display("FAIL pulse_rinc got %b exp 1", rinc); end
    step();
    hold_empty = 1'b1;
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      tests++; if (rinc !== 1'b0) begin fails++; $display("FAIL pulse_rinc_low cyc%0d got %b exp 0", i, rinc); end
      tests++; if (m_level !== 2'd1) begin fails++; $display("FAIL pulse_level cyc%0d got %0d exp 1", i, m_level); end
      step();
    end
    tests++; if (m_data !== 8'h5A) begin fails++; $display("FAIL pulse_data got %h exp 5a", m_data); end
    quiesce();
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    logic [7:0] nxt = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      m_ready    = ($urandom_range(0, 1) == 1);
      hold_empty = ($urandom_range(0, 3) == 0);
      while (src.size() < 4) begin
        src.push_back(nxt);
        nxt++;
      end
      drive_fifo();
      tests++; if (m_level > 2'd2) begin fails++; $display("FAIL rand_level_max cyc%0d got %0d", i, m_level); end
      tests++; if (m_level !== 2'(sb.size())) begin fails++; $display("FAIL rand_level cyc%0d got %0d exp %0d", i, m_level, sb.size()); end
      tests++; if (m_valid !== (sb.size() != 0)) begin fails++; $display("FAIL rand_valid cyc%0d got %b exp %b", i, m_valid, sb.size() != 0); end
      if (m_valid && m_ready && (sb.size() != 0)) begin
        tests++; if (m_data !== sb[0]) begin fails++; $display("FAIL rand_data cyc%0d got %h exp %h", i, m_data, sb[0]); end
        sb.delete(0);
      end
      if (rinc) sb.push_back(rdata[7:0]);
      step();
    end
    quiesce();
  endtask

  task automatic test_midreset();
    src = '{8'hC1, 8'hC2, 8'hC3};
    m_ready = 1'b0;
    drive_fifo();
    step();
    step();
    #2;
    rrst_n = 1'b0;
    #1;
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b exp 0", m_valid); end
    tests++; if (m_level !== 2'd0) begin fails++; $display("FAIL midrst_level got %0d exp 0", m_level); end
    tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL midrst_data got %h exp 00", m_data); end
    src.delete();
    drive_fifo();
    step();
    rrst_n = 1'b1;
    #1;
  endtask

`ifdef RD_FWFT_PARITY_EN
  task automatic test_parity();
    src = '{8'h03};
    bad_par = 1'b1;
    m_ready = 1'b0;
    drive_fifo();
    tests++; if (perr !== 1'b0) begin fails++; $display("FAIL par_pre got %b exp 0", perr); end
    step();
    bad_par = 1'b0;
    drive_fifo();
    tests++; if (perr !== 1'b1) begin fails++; $display("FAIL par_set got %b exp 1", perr); end
    tests++; if (m_data !== 8'h03) begin fails++; $display("FAIL par_data got %h exp 03", m_data); end
    quiesce();
    step();
    tests++; if (perr !== 1'b1) begin fails++; $display("FAIL par_sticky got %b exp 1", perr); end
    rrst_n = 1'b0;
    #1;
    tests++; if (perr !== 1'b0) begin fails++; $display("FAIL par_clear got %b exp 0", perr); end
    step();
    rrst_n = 1'b1;
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_pulse();
    test_midreset();
`ifdef RD_FWFT_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
